// File: rtl/sram_lane_adapter_if.sv
// Host and SRAM-pin bundle for sram_lane_adapter.
// The slave modport is the adapter; the master modport is the surrounding system.
interface sram_lane_adapter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = (LANES > 1) ? $clog2(LANES) : 0;

    logic                 req;
    logic                 we;
    logic                 wide;
    logic [ADDR_W+LB-1:0] addr;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    rdata;
    logic                 ready;
    logic                 ack;

    logic [ADDR_W-1:0]    sram_addr;
    logic [LANES-1:0]     sram_be_n;
    logic                 sram_we_n;
    logic                 sram_oe_n;
    logic [DATA_W-1:0]    sram_dq_o;
    logic                 sram_dq_oe;
    logic [DATA_W-1:0]    sram_dq_i;

    modport master (
        output req, we, wide, addr, wdata, sram_dq_i,
        input  rdata, ready, ack, sram_addr, sram_be_n,
        input  sram_we_n, sram_oe_n, sram_dq_o, sram_dq_oe
    );

    modport slave (
        input  req, we, wide, addr, wdata, sram_dq_i,
        output rdata, ready, ack, sram_addr, sram_be_n,
        output sram_we_n, sram_oe_n, sram_dq_o, sram_dq_oe
    );
endinterface

// File: rtl/sram_lane_adapter.sv
// Byte/word host port to an asynchronous SRAM with byte lanes and wait states.
// Optional single-word read cache enabled by defining SRAM_LANE_PREFETCH_EN.
module sram_lane_adapter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 20,
    parameter int WAIT_STATES = 1
) (
    input logic                sysclk,
    input logic                reset_n,
    sram_lane_adapter_if.slave bus
);
    localparam int LANES = DATA_W / 8;
    localparam int LB    = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int LW    = (LB > 0) ? LB : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_wide;
    logic [LW-1:0]     r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [LANES-1:0]  r_be_n;
    logic [DATA_W-1:0] r_dq;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_wcnt;

    logic [LW-1:0]     w_lane;
    logic              w_wide;
    logic [ADDR_W-1:0] w_waddr;
    logic [LANES-1:0]  w_be_n;
    logic [DATA_W-1:0] w_dq;
    logic              w_accept;
    logic              w_capture;
    logic              w_active;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    function automatic logic [DATA_W-1:0] f_pick(
        input logic [DATA_W-1:0] word,
        input logic              wide,
        input logic [LW-1:0]     lane
    );
        f_pick = '0;
        if (wide) begin
            f_pick = word;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (int'(lane) == i) f_pick[7:0] = word[8*i +: 8];
            end
        end
    endfunction

    // A single-lane bus has no byte select: every access is a full word.
    generate
        if (LB == 0) begin : g_one_lane
            assign w_lane = '0;
            assign w_wide = 1'b1;
        end else begin : g_multi_lane
            assign w_lane = bus.addr[LB-1:0];
            assign w_wide = bus.wide;
        end
    endgenerate

    assign w_waddr   = bus.addr[ADDR_W+LB-1:LB];
    assign w_accept  = (r_state == S_IDLE) && bus.req;
    assign w_capture = (r_state == S_STROBE) && (r_wcnt == 3'd0);
    assign w_active  = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                       (r_state == S_HOLD);
    assign w_dq      = w_wide ? bus.wdata : {LANES{bus.wdata[7:0]}};

    always_comb begin
        w_be_n = '1;
        for (int i = 0; i < LANES; i++) begin
            if (w_wide || (int'(w_lane) == i)) w_be_n[i] = 1'b0;
        end
    end

`ifdef SRAM_LANE_PREFETCH_EN
    logic              r_cvalid;
    logic [ADDR_W-1:0] r_caddr;
    logic [DATA_W-1:0] r_cword;
    logic [DATA_W-1:0] r_raw;

    assign w_hit      = r_cvalid && !bus.we && (r_caddr == w_waddr);
    assign w_hit_data = f_pick(r_cword, w_wide, w_lane);

    // r_raw tracks the word that the DONE cycle writes back into the entry.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_cvalid <= 1'b0;
            r_caddr  <= '0;
            r_cword  <= '0;
            r_raw    <= '0;
        end else begin
            if (w_capture && !r_we) r_raw <= bus.sram_dq_i;
            else if (w_accept && w_hit) r_raw <= r_cword;
            if (w_accept && bus.we) begin
                r_cvalid <= 1'b0;
            end else if ((r_state == S_DONE) && !r_we) begin
                r_cvalid <= 1'b1;
                r_caddr  <= r_addr;
                r_cword  <= r_raw;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.req) w_next = w_hit ? S_DONE : S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (r_wcnt == 3'd0) w_next = S_HOLD;
            S_HOLD:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_wide  <= 1'b0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_be_n  <= '1;
            r_dq    <= '0;
            r_rdata <= '0;
            r_wcnt  <= '0;
        end else begin
            if (w_accept) begin
                r_we   <= bus.we;
                r_wide <= w_wide;
                r_lane <= w_lane;
                r_addr <= w_waddr;
                r_be_n <= w_be_n;
                r_wcnt <= 3'(WAIT_STATES);
                if (bus.we) r_dq <= w_dq;
            end
            if ((r_state == S_STROBE) && (r_wcnt != 3'd0)) r_wcnt <= r_wcnt - 3'd1;
            if (w_capture && !r_we) begin
                r_rdata <= f_pick(bus.sram_dq_i, r_wide, r_lane);
            end else if (w_accept && w_hit) begin
                r_rdata <= w_hit_data;
            end
        end
    end

    // Strobes decode straight from the state flop so reset drops them at once.
    assign bus.sram_addr  = r_addr;
    assign bus.sram_be_n  = w_active ? r_be_n : '1;
    assign bus.sram_we_n  = !((r_state == S_STROBE) && r_we);
    assign bus.sram_oe_n  = !((r_state == S_STROBE) && !r_we);
    assign bus.sram_dq_oe = w_active && r_we;
    assign bus.sram_dq_o  = r_dq;
    assign bus.rdata      = r_rdata;
    assign bus.ready      = (r_state == S_IDLE);
    assign bus.ack        = (r_state == S_DONE);
endmodule

// File: tb/tb_sram_lane_adapter.sv
// Directed and random checks of sram_lane_adapter against a byte-array memory model.
// A second 32-bit instance covers the four-lane word write.
module tb_sram_lane_adapter;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int WS = 1;
`ifdef SRAM_LANE_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] sram_mem [64];
    logic [7:0]  mdl [128];
    bit          c_valid = 1'b0;
    logic [19:0] c_addr  = '0;
    logic [15:0] last_rd = '0;

    sram_lane_adapter_if #(.DATA_W(DW), .ADDR_W(AW)) bus16 ();
    sram_lane_adapter_if #(.DATA_W(32), .ADDR_W(AW)) bus32 ();

    sram_lane_adapter #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)) u_dut (
        .sysclk (clk),
        .reset_n(rst_n),
        .bus    (bus16)
    );

    sram_lane_adapter #(.DATA_W(32), .ADDR_W(AW), .WAIT_STATES(WS)) u_dut32 (
        .sysclk (clk),
        .reset_n(rst_n),
        .bus    (bus32)
    );

    assign bus16.sram_dq_i = !bus16.sram_oe_n ? sram_mem[bus16.sram_addr[5:0]] : 16'h0BAD;
    assign bus32.sram_dq_i = '0;

    // Behavioural SRAM: lanes written mid-cycle while we_n is low.
    always @(negedge clk) begin
        if (!bus16.sram_we_n) begin
            for (int i = 0; i < 2; i++) begin
                if (!bus16.sram_be_n[i])
                    sram_mem[bus16.sram_addr[5:0]][8*i +: 8] = bus16.sram_dq_o[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic acc(
        input  logic iwe, input logic iwide, input logic [20:0] ia, input logic [15:0] iwd,
        output logic [15:0] ord, output int lat, output int nwe, output int noe,
        output int ndq, output int oeb, output logic [19:0] sa, output logic [1:0] be,
        output logic [15:0] dq
    );
        ord = '0; lat = -1; nwe = 0; noe = 0; ndq = 0; oeb = 0;
        sa = '1; be = '1; dq = '0;
        @(posedge clk); #1;
        bus16.req = 1'b1; bus16.we = iwe; bus16.wide = iwide;
        bus16.addr = ia; bus16.wdata = iwd;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            bus16.req = 1'b0;
            if (bus16.ack) begin
                lat = c;
                ord = bus16.rdata;
                break;
            end
            if (!bus16.sram_we_n) nwe++;
            if (!bus16.sram_oe_n) noe++;
            if (!bus16.sram_oe_n && bus16.sram_dq_oe) oeb++;
            if (bus16.sram_be_n != 2'b11) begin
                sa = bus16.sram_addr;
                be = bus16.sram_be_n;
            end
            if (bus16.sram_dq_oe) begin
                ndq++;
                dq = bus16.sram_dq_o;
            end
        end
    endtask

    task automatic txn(input logic iwe, input logic iwide, input logic [20:0] a, input logic [15:0] wd);
        logic [15:0] rd, exp, dq;
        logic [19:0] sa;
        logic [1:0]  be, exp_be;
        int          lat, nwe, noe, ndq, oeb, ia, base;
        bit          hit;
        ia     = int'(a[6:0]);
        base   = int'({a[6:1], 1'b0});
        hit    = PF && !iwe && c_valid && (c_addr == a[20:1]);
        exp    = iwide ? {mdl[base+1], mdl[base]} : {8'h00, mdl[ia]};
        exp_be = iwide ? 2'b00 : (a[0] ? 2'b01 : 2'b10);
        acc(iwe, iwide, a, wd, rd, lat, nwe, noe, ndq, oeb, sa, be, dq);
        chk("latency", lat, hit ? 1 : WS + 4);
        if (iwe) begin
            chk("wr_we_cycles", nwe, WS + 1);
            chk("wr_oe_cycles", noe, 0);
            chk("wr_dqoe_cycles", ndq, WS + 3);
            chk("wr_sram_addr", sa, a[20:1]);
            chk("wr_be_n", be, exp_be);
            chk("wr_dq", dq, iwide ? wd : {wd[7:0], wd[7:0]});
            chk("rdata_hold", rd, last_rd);
            if (iwide) begin
                mdl[base]   = wd[7:0];
                mdl[base+1] = wd[15:8];
            end else begin
                mdl[ia] = wd[7:0];
            end
            c_valid = 1'b0;
        end else begin
            chk("rd_oe_cycles", noe, hit ? 0 : WS + 1);
            chk("rd_we_cycles", nwe, 0);
            chk("rd_dqoe_cycles", ndq, 0);
            chk("rd_oe_dq_clash", oeb, 0);
            chk("rd_data", rd, exp);
            if (!hit) begin
                chk("rd_sram_addr", sa, a[20:1]);
                chk("rd_be_n", be, exp_be);
                c_valid = 1'b1;
                c_addr  = a[20:1];
            end
            last_rd = rd;
        end
    endtask

    initial begin
        int acks, nwe;
        logic [19:0] sa32;
        logic [3:0]  be32;
        logic [31:0] dq32;

        bus16.req = 0; bus16.we = 0; bus16.wide = 0; bus16.addr = '0; bus16.wdata = '0;
        bus32.req = 0; bus32.we = 0; bus32.wide = 0; bus32.addr = '0; bus32.wdata = '0;
        for (int w = 0; w < 64; w++) begin
            sram_mem[w] = 16'($urandom);
            mdl[2*w]    = sram_mem[w][7:0];
            mdl[2*w+1]  = sram_mem[w][15:8];
        end

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", bus16.ack, 1'b0);
        chk("rst_rdata", bus16.rdata, 16'h0);
        chk("rst_sram_addr", bus16.sram_addr, 20'h0);
        chk("rst_be_n", bus16.sram_be_n, 2'b11);
        chk("rst_we_n", bus16.sram_we_n, 1'b1);
        chk("rst_oe_n", bus16.sram_oe_n, 1'b1);
        chk("rst_dq_oe", bus16.sram_dq_oe, 1'b0);
        chk("rst_dq_o", bus16.sram_dq_o, 16'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", bus16.ready, 1'b1);

        // Byte write to the upper lane, then byte read of a known word
        txn(1'b1, 1'b0, 21'h00003, 16'h00A5);
        sram_mem[1] = 16'h3C7E;
        mdl[2] = 8'h7E;
        mdl[3] = 8'h3C;
        txn(1'b0, 1'b0, 21'h00002, 16'h0000);

        // A req pulse during STROBE is dropped
        @(posedge clk); #1;
        bus16.req = 1'b1; bus16.we = 1'b0; bus16.wide = 1'b0; bus16.addr = 21'h20;
        acks = 0; nwe = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            bus16.req = (c == 2);
            if (c == 2) begin
                bus16.we = 1'b1; bus16.addr = 21'h22; bus16.wdata = 16'h0077;
            end
            if (bus16.ack) begin
                acks++;
                chk("pulse_rdata", bus16.rdata, {8'h00, mdl[32]});
                last_rd = bus16.rdata;
            end
            if (!bus16.sram_we_n) nwe++;
        end
        bus16.req = 1'b0;
        c_valid = 1'b1;
        c_addr  = 20'h10;
        chk("pulse_acks", acks, 1);
        chk("pulse_no_write", nwe, 0);
        txn(1'b0, 1'b0, 21'h00022, 16'h0000);

        // Four-lane word write on the 32-bit instance
        @(posedge clk); #1;
        bus32.req = 1'b1; bus32.we = 1'b1; bus32.wide = 1'b1;
        bus32.addr = 22'h4; bus32.wdata = 32'hDEADBEEF;
        acks = 0; sa32 = '1; be32 = '1; dq32 = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            bus32.req = 1'b0;
            if (bus32.ack) acks++;
            if (bus32.sram_be_n != 4'hF) begin
                sa32 = bus32.sram_addr;
                be32 = bus32.sram_be_n;
                dq32 = bus32.sram_dq_o;
            end
        end
        chk("w32_sram_addr", sa32, 20'h1);
        chk("w32_be_n", be32, 4'b0000);
        chk("w32_dq", dq32, 32'hDEADBEEF);
        chk("w32_acks", acks, 1);

        // Random traffic
        for (int k = 0; k < 48; k++) begin
            txn(1'($urandom), 1'($urandom), 21'($urandom_range(0, 127)), 16'($urandom));
        end

        // Repeated reads of one word, then a write invalidating any held copy
        txn(1'b0, 1'b0, 21'h00010, 16'h0000);
        txn(1'b0, 1'b0, 21'h00011, 16'h0000);
        txn(1'b0, 1'b1, 21'h00010, 16'h0000);
        txn(1'b1, 1'b0, 21'h00040, 16'h005A);
        txn(1'b0, 1'b0, 21'h00010, 16'h0000);

        // Reset during the second STROBE cycle of a write
        @(posedge clk); #1;
        bus16.req = 1'b1; bus16.we = 1'b1; bus16.wide = 1'b0;
        bus16.addr = 21'h5; bus16.wdata = 16'h003C;
        @(posedge clk); #1;
        bus16.req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_strobe", bus16.sram_we_n, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_n", bus16.sram_we_n, 1'b1);
        chk("abort_dq_oe", bus16.sram_dq_oe, 1'b0);
        chk("abort_be_n", bus16.sram_be_n, 2'b11);
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rst_n = 1'b1;
            @(posedge clk); #1;
            if (bus16.ack) acks++;
        end
        chk("abort_acks", acks, 0);
        chk("abort_ready", bus16.ready, 1'b1);
        mdl[5]  = 8'h3C;
        c_valid = 1'b0;
        last_rd = '0;
        txn(1'b0, 1'b0, 21'h00005, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
